// File: rtl/softmax_row_recip_if.sv
// Row-in / reciprocal-vector-out handshake bundle for softmax_row_recip.
// Lanes and entries are Q2.13; index j is column j (input) or row j (output).
interface softmax_row_recip_if;
    logic               I_VLD;
    logic [0:15][15:0]  I_ROW;
    logic               O_RDY;
    logic               O_VLD;
    logic               I_RDY;
    logic [0:15][15:0]  O_VEC;

    modport master (output I_VLD, I_ROW, I_RDY, input O_RDY, O_VLD, O_VEC);
    modport slave  (input I_VLD, I_ROW, I_RDY, output O_RDY, O_VLD, O_VEC);
endinterface

// File: rtl/softmax_row_recip.sv
// Per-row softmax normaliser: sums 16 Q2.13 rows, then emits 1/sum per row via a restoring divider.
// Define SOFTMAX_RECIP_ROUND_EN for a 16-iteration divider with half-up rounding (else truncation).
module softmax_row_recip (
    input logic                I_CLK,
    input logic                I_RST,
    softmax_row_recip_if.slave bus
);

`ifdef SOFTMAX_RECIP_ROUND_EN
    localparam int unsigned NumIter = 16;
`else
    localparam int unsigned NumIter = 15;
`endif
    localparam logic [4:0] LastIter = 5'(NumIter);

    typedef enum logic [1:0] {StLoad, StDiv, StOut} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              row_q, row_d;
    logic [3:0]              div_row_q, div_row_d;
    logic [4:0]              iter_q, iter_d;
    logic [19:0]             rem_q, rem_d;
    logic [NumIter-1:0]      quo_q, quo_d;
    logic                    sat_q, sat_d;
    logic [0:15][19:0]       sum_buf;
    logic [0:15][15:0]       vec_q;

    logic                    beat;
    logic                    vec_we;
    logic [19:0]             row_sum;
    logic [19:0]             divisor;
    logic [20:0]             rem_shift;
    logic [19:0]             rem_sub;
    logic                    rem_ge;
    logic [NumIter-1:0]      quo_next;
    logic [15:0]             result;

    // Negative lanes count as zero.
    always_comb begin
        row_sum = '0;
        for (int j = 0; j < 16; j++) begin
            row_sum = row_sum + (bus.I_ROW[j][15] ? 20'd0 : {5'd0, bus.I_ROW[j][14:0]});
        end
    end

    // One restoring step; remainder stays below the divisor so 20 bits suffice after subtracting.
    always_comb begin
        divisor   = sum_buf[div_row_q];
        rem_shift = {rem_q, 1'b0};
        rem_ge    = rem_shift >= {1'b0, divisor};
        rem_sub   = rem_shift[19:0] - divisor;
        quo_next  = {quo_q[NumIter-2:0], rem_ge};
`ifdef SOFTMAX_RECIP_ROUND_EN
        result    = {1'b0, quo_next[15:1]} + 16'(quo_next[0]);
        if (result[15]) result = 16'h7FFF;
`else
        result    = {1'b0, quo_next};
`endif
        if (sat_q) result = 16'h7FFF;
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        div_row_d = div_row_q;
        iter_d    = iter_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        sat_d     = sat_q;
        beat      = 1'b0;
        vec_we    = 1'b0;
        unique case (state_q)
            StLoad: begin
                beat = bus.I_VLD;
                if (beat) begin
                    row_d = row_q + 4'd1;
                    if (row_q == 4'd15) begin
                        state_d   = StDiv;
                        div_row_d = '0;
                        iter_d    = '0;
                    end
                end
            end
            StDiv: begin
                if (iter_q == 5'd0) begin
                    // Q < 2^15 whenever S > 2048, so the dividend's top bits 2^26 >> 15 seed the remainder.
                    sat_d  = divisor <= 20'd2048;
                    rem_d  = 20'd2048;
                    quo_d  = '0;
                    iter_d = 5'd1;
                end else begin
                    rem_d = rem_ge ? rem_sub : rem_shift[19:0];
                    quo_d = quo_next;
                    if (iter_q == LastIter) begin
                        vec_we    = 1'b1;
                        iter_d    = '0;
                        div_row_d = div_row_q + 4'd1;
                        if (div_row_q == 4'd15) state_d = StOut;
                    end else begin
                        iter_d = iter_q + 5'd1;
                    end
                end
            end
            StOut: begin
                if (bus.I_RDY) begin
                    state_d = StLoad;
                    row_d   = '0;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q   <= StLoad;
            row_q     <= '0;
            div_row_q <= '0;
            iter_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            sat_q     <= 1'b0;
            sum_buf   <= '0;
            vec_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            div_row_q <= div_row_d;
            iter_q    <= iter_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            sat_q     <= sat_d;
            if (beat)   sum_buf[row_q]   <= row_sum;
            if (vec_we) vec_q[div_row_q] <= result;
        end
    end

    assign bus.O_RDY = (state_q == StLoad);
    assign bus.O_VLD = (state_q == StOut);
    assign bus.O_VEC = vec_q;

endmodule

// File: tb/tb_softmax_row_recip.sv
// Self-checking bench for softmax_row_recip: directed table tile, uniform tile, randomized tiles
// against an arithmetic reference, back-pressure, and resets during LOAD and DIV.
module tb_softmax_row_recip;

`ifdef SOFTMAX_RECIP_ROUND_EN
    localparam int DL  = 17;
    localparam logic [15:0] EXP_AAA  = 16'h0AAB;
    localparam logic [15:0] EXP_2AAA = 16'h2AAB;
`else
    localparam int DL  = 16;
    localparam logic [15:0] EXP_AAA  = 16'h0AAA;
    localparam logic [15:0] EXP_2AAA = 16'h2AAA;
`endif
    localparam int LAT = 16 * DL;

    typedef struct {
        logic [0:15][15:0] row;
        logic [15:0]       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    softmax_row_recip_if bus();

    softmax_row_recip dut (
        .I_CLK (clk),
        .I_RST (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned xfers = 0;
    always @(posedge clk) if (!rst && bus.I_VLD && bus.O_RDY) xfers <= xfers + 1;

    int checks   = 0;
    int failures = 0;

    vec_t                     tbl [16];
    logic [0:15][0:15][15:0]  tile;
    logic [0:15][15:0]        exp_vec;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: reciprocal of the clamped row sum in Q2.13, straight from real-valued arithmetic.
    function automatic logic [15:0] ref_recip(input logic [0:15][15:0] row);
        longint s = 0;
        longint q;
        for (int j = 0; j < 16; j++) if (row[j] < 16'h8000) s += longint'(row[j]);
        if (s <= 2048) return 16'h7FFF;
`ifdef SOFTMAX_RECIP_ROUND_EN
        q = ((longint'(1) << 27) + s) / (2 * s);
`else
        q = (longint'(1) << 26) / s;
`endif
        if (q > 32767) q = 32767;
        return 16'(q);
    endfunction

    function automatic logic [0:15][15:0] rand_row();
        logic [0:15][15:0] r;
        int kind = $urandom_range(3);
        int idx  = $urandom_range(15);
        for (int j = 0; j < 16; j++) begin
            case (kind)
                0:       r[j] = 16'($urandom);
                1:       r[j] = ($urandom_range(3) == 0) ? 16'($urandom_range(255)) : 16'h0;
                2:       r[j] = (j == idx) ? 16'($urandom_range(4095)) : 16'h0;
                default: r[j] = 16'($urandom_range(32767));
            endcase
        end
        return r;
    endfunction

    task automatic rand_tile();
        for (int r = 0; r < 16; r++) begin
            tile[r]    = rand_row();
            exp_vec[r] = ref_recip(tile[r]);
        end
    endtask

    task automatic send_rows(input int n, input int gap_pct);
        for (int r = 0; r < n; r++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                bus.I_VLD = 1'b0;
                bus.I_ROW = rand_row();
                @(posedge clk); #1;
            end
            bus.I_VLD = 1'b1;
            bus.I_ROW = tile[r];
            @(posedge clk); #1;
        end
        bus.I_VLD = 1'b0;
    endtask

    task automatic wait_out(input bit chk_lat, input bit pulses);
        int n = 0;
        while (!bus.O_VLD && n < 400) begin
            if (pulses) begin
                bus.I_VLD = 1'($urandom_range(1));
                bus.I_ROW = rand_row();
            end
            @(posedge clk); #1;
            n++;
        end
        bus.I_VLD = 1'b0;
        check("o_vld_reached", bus.O_VLD, 1);
        if (chk_lat) check("latency", n, LAT);
    endtask

    task automatic check_vec(input string name);
        for (int r = 0; r < 16; r++) check($sformatf("%s[%0d]", name, r), bus.O_VEC[r], exp_vec[r]);
    endtask

    task automatic handshake(input int hold, input bit pulses);
        for (int i = 0; i < hold; i++) begin
            bus.I_RDY = 1'b0;
            if (pulses) begin
                bus.I_VLD = 1'($urandom_range(1));
                bus.I_ROW = rand_row();
            end
            @(posedge clk); #1;
            check("hold_vld", bus.O_VLD, 1);
            check("hold_vec", bus.O_VEC === exp_vec, 1);
        end
        bus.I_VLD = 1'b0;
        bus.I_RDY = 1'b1;
        @(posedge clk); #1;
        check("post_h_vld", bus.O_VLD, 0);
        check("post_h_rdy", bus.O_RDY, 1);
        bus.I_RDY = 1'b0;
    endtask

    task automatic run_tile(input string name, input int gap_pct, input bit pulses,
                            input int hold, input bit chk_lat);
        int unsigned x0 = xfers;
        send_rows(16, gap_pct);
        check("o_rdy_div", bus.O_RDY, 0);
        wait_out(chk_lat, pulses);
        check_vec(name);
        handshake(hold, pulses);
        check("xfers", longint'(xfers - x0), 16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) tbl[i].row = '0;
        for (int j = 0; j < 16; j++) begin
            tbl[0].row[j] = 16'h2000;
            tbl[4].row[j] = 16'h8000;
            tbl[7].row[j] = 16'h7FFF;
        end
        tbl[0].exp = 16'h0200;
        tbl[1].row[0] = 16'h2000;                            tbl[1].exp  = 16'h2000;
        tbl[2].row[0] = 16'h0801;                            tbl[2].exp  = 16'h7FF0;
                                                             tbl[3].exp  = 16'h7FFF;
                                                             tbl[4].exp  = 16'h7FFF;
        tbl[5].row[0] = 16'h0800;                            tbl[5].exp  = 16'h7FFF;
        tbl[6].row[0] = 16'h2000; tbl[6].row[1] = 16'h2000; tbl[6].row[2] = 16'h2000;
                                                             tbl[6].exp  = EXP_AAA;
                                                             tbl[7].exp  = 16'h0080;
        tbl[8].row[0] = 16'hFFFF; tbl[8].row[5] = 16'h2000;  tbl[8].exp  = 16'h2000;
        tbl[9].row[15] = 16'h4000;                           tbl[9].exp  = 16'h1000;
        tbl[10].row[3] = 16'h2000; tbl[10].row[9] = 16'h2000; tbl[10].exp = 16'h1000;
        tbl[11].row[0] = 16'h0001; tbl[11].row[1] = 16'h0800; tbl[11].exp = 16'h7FF0;
        for (int j = 0; j < 4; j++) tbl[12].row[j] = 16'h2000;
                                                             tbl[12].exp = 16'h0800;
        tbl[13].row[0] = 16'h6000;                           tbl[13].exp = EXP_AAA;
        tbl[14].row[0] = 16'h0C00;                           tbl[14].exp = 16'h5555;
        tbl[15].row[0] = 16'h1800;                           tbl[15].exp = EXP_2AAA;

        bus.I_VLD = 1'b0;
        bus.I_ROW = '0;
        bus.I_RDY = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_rdy", bus.O_RDY, 1);
        check("rst_vld", bus.O_VLD, 0);
        check("rst_vec", bus.O_VEC === '0, 1);
        @(posedge clk); #1;

        // Directed table, back-to-back beats.
        for (int r = 0; r < 16; r++) begin
            tile[r]    = tbl[r].row;
            exp_vec[r] = tbl[r].exp;
        end
        run_tile("table", 0, 1'b0, 0, 1'b1);

        // Uniform 0x2000 tile.
        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j < 16; j++) tile[r][j] = 16'h2000;
            exp_vec[r] = 16'h0200;
        end
        run_tile("uniform", 0, 1'b0, 2, 1'b1);

        // Back-pressure: input gaps, pulses during DIV/OUT, 10-cycle stall.
        rand_tile();
        run_tile("backpressure", 40, 1'b1, 10, 1'b0);

        for (int t = 0; t < 4; t++) begin
            rand_tile();
            run_tile("random", 20, 1'b1, t, 1'b1);
        end

        // Reset while dividing row 7.
        rand_tile();
        send_rows(16, 0);
        repeat (7 * DL + 5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("divrst_vld", bus.O_VLD, 0);
        check("divrst_rdy", bus.O_RDY, 1);
        check("divrst_vec", bus.O_VEC === '0, 1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        rand_tile();
        run_tile("after_divrst", 10, 1'b0, 1, 1'b1);

        // Reset after a partial load; the next tile must start at row 0.
        rand_tile();
        send_rows(5, 0);
        #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        rand_tile();
        run_tile("after_loadrst", 0, 1'b0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
